// File: rtl/mux_n_pipe_if.sv
// mux_n_pipe_if: valid/ready bus for the N:1 pipelined selector.
// The upstream side carries flattened channels plus a select. The
// downstream side carries the selected word. Also carries flush and the
// sticky select-error flag.
interface mux_n_pipe_if #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 2,
  parameter int SEL_W  = 1
);
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    flush;
  logic                    sel_err;

  // Selector stage side
  modport slave (
    input  in_data, sel, in_valid, out_ready, flush,
    output in_ready, out_data, out_valid, sel_err
  );

  // Producer/consumer side (drives the stage)
  modport master (
    output in_data, sel, in_valid, out_ready, flush,
    input  in_ready, out_data, out_valid, sel_err
  );
endinterface

// File: rtl/mux_n_pipe.sv
// mux_n_pipe: N:1 selector with one registered stage and a 2-entry skid
// buffer, so in_ready is a flop and the stage streams at one word per cycle
// under backpressure.
// Optional build macro MUX_N_PIPE_SEL_CHECK_EN: adds a sticky sel_err flag.
// The flag is set by any accept whose select is >= NUM_IN. Without the
// macro, sel_err is tied low. Out-of-range selects always yield a zero word.
module mux_n_pipe #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 2,
  parameter int SEL_W  = 1
) (
  input logic        clk,
  input logic        rst,
  mux_n_pipe_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,   // nothing held
    ST_ONE   = 2'd1,   // main register valid, skid empty
    ST_FULL  = 2'd2    // main and skid both valid
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_main_data;
  logic [WIDTH-1:0] w_main_next;
  logic [WIDTH-1:0] r_skid_data;
  logic [WIDTH-1:0] w_skid_next;
  logic             r_in_ready;
  logic             w_in_ready_next;

  logic [WIDTH-1:0] w_chan [NUM_IN];
  logic [WIDTH-1:0] w_sel_word;
  logic             w_accept;
  logic             w_xfer;

  // Split the flattened input bus into one word per channel
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_chan
      assign w_chan[gi] = bus.in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Channel select; any select with no matching channel produces zero
  always_comb begin
    w_sel_word = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (bus.sel == SEL_W'(k)) begin
        w_sel_word = w_chan[k];
      end
    end
  end

  assign w_accept = bus.in_valid & r_in_ready;
  assign w_xfer   = (r_state != ST_EMPTY) & bus.out_ready;

  // Next-state and next-data for the main/skid pair
  always_comb begin
    w_state_next = r_state;
    w_main_next  = r_main_data;
    w_skid_next  = r_skid_data;
    if (bus.flush) begin
      // Drop everything held. out_data keeps its last value.
      w_state_next = ST_EMPTY;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_main_next  = w_sel_word;
            w_state_next = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_xfer) begin
            w_main_next = w_sel_word;
          end else if (w_accept) begin
            w_skid_next  = w_sel_word;
            w_state_next = ST_FULL;
          end else if (w_xfer) begin
            w_state_next = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the drain case matters
          if (w_xfer) begin
            w_main_next  = r_skid_data;
            w_state_next = ST_ONE;
          end
        end
        default: begin
          w_state_next = ST_EMPTY;
        end
      endcase
    end
    w_in_ready_next = (w_state_next != ST_FULL);
  end

  // State, data and registered in_ready update
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_main_data <= '0;
      r_skid_data <= '0;
      r_in_ready  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_main_data <= w_main_next;
      r_skid_data <= w_skid_next;
      r_in_ready  <= w_in_ready_next;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = (r_state != ST_EMPTY);
  assign bus.out_data  = r_main_data;

`ifdef MUX_N_PIPE_SEL_CHECK_EN
  logic r_sel_err;
  logic w_sel_oob;

  // Out of range only when the select field can encode more than NUM_IN
  // values; for a full power-of-two decode this folds to constant zero.
  assign w_sel_oob = (32'(bus.sel) >= 32'(NUM_IN));

  // Sticky flag: set by an out-of-range accept, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel_err <= 1'b0;
    end else if (w_accept && w_sel_oob) begin
      r_sel_err <= 1'b1;
    end
  end

  assign bus.sel_err = r_sel_err;
`else
  assign bus.sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_n_pipe.sv
// tb_mux_n_pipe: directed checks plus a random stream for mux_n_pipe.
// It uses three configurations: 2x5-bit, 4x8-bit and 3x5-bit with a
// 2-bit select.
module tb_mux_n_pipe;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mux_n_pipe_if #(.WIDTH(5), .NUM_IN(2), .SEL_W(1)) if2 ();
  mux_n_pipe_if #(.WIDTH(8), .NUM_IN(4), .SEL_W(2)) if4 ();
  mux_n_pipe_if #(.WIDTH(5), .NUM_IN(3), .SEL_W(2)) if3 ();

  mux_n_pipe #(.WIDTH(5), .NUM_IN(2), .SEL_W(1)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (if2.slave)
  );

  mux_n_pipe #(.WIDTH(8), .NUM_IN(4), .SEL_W(2)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4.slave)
  );

  mux_n_pipe #(.WIDTH(5), .NUM_IN(3), .SEL_W(2)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (if3.slave)
  );

`ifdef MUX_N_PIPE_SEL_CHECK_EN
  localparam logic [31:0] EXP_ERR = 32'd1;
`else
  localparam logic [31:0] EXP_ERR = 32'd0;
`endif

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] build4(input logic [7:0] w, input int ch);
    logic [31:0] d;
    d = 32'hEEEE_EEEE;
    d[ch*8 +: 8] = w;
    return d;
  endfunction

  function automatic logic [7:0] pick4(input logic [31:0] d, input logic [1:0] s);
    return d[s*8 +: 8];
  endfunction

  logic [4:0]  sw [4];
  logic [7:0]  q [$];
  logic [7:0]  exp_w;
  logic        stall;
  logic        hold_in;
  logic [7:0]  held;

  initial begin
    sw = '{5'h03, 5'h1F, 5'h10, 5'h0C};
    rst = 1'b1;
    if2.in_data = {5'h1A, 5'h05}; if2.sel = 1'b1; if2.in_valid = 1'b1;
    if2.out_ready = 1'b1; if2.flush = 1'b0;
    if4.in_data = '0; if4.sel = '0; if4.in_valid = 1'b0;
    if4.out_ready = 1'b1; if4.flush = 1'b0;
    if3.in_data = '0; if3.sel = '0; if3.in_valid = 1'b0;
    if3.out_ready = 1'b1; if3.flush = 1'b0;

    // Reset held for two cycles with in_valid asserted
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_out_valid", 32'(if2.out_valid), 32'd0);
      check("rst_out_data", 32'(if2.out_data), 32'd0);
      check("rst_in_ready", 32'(if2.in_ready), 32'd0);
      check("rst_sel_err", 32'(if2.sel_err), 32'd0);
    end
    rst = 1'b0;
    step();
    check("post_rst_in_ready", 32'(if2.in_ready), 32'd1);
    check("post_rst_out_valid", 32'(if2.out_valid), 32'd0);

    // sel=1 picks the upper channel; then sel=0 picks the lower one
    step();
    check("sel1_valid", 32'(if2.out_valid), 32'd1);
    check("sel1_data", 32'(if2.out_data), 32'h1A);
    if2.sel = 1'b0;
    step();
    check("sel0_data", 32'(if2.out_data), 32'h05);

    // Streaming: one new word per cycle, in order
    for (int i = 0; i < 4; i++) begin
      if2.sel = 1'(i % 2);
      if2.in_data = (i % 2 == 1) ? {sw[i], ~sw[i]} : {~sw[i], sw[i]};
      step();
      check("stream_valid", 32'(if2.out_valid), 32'd1);
      check("stream_data", 32'(if2.out_data), 32'(sw[i]));
      check("stream_in_ready", 32'(if2.in_ready), 32'd1);
    end
    if2.in_valid = 1'b0;
    step();
    check("stream_drained", 32'(if2.out_valid), 32'd0);

    // Backpressure: fill main and skid, third word must wait
    if4.out_ready = 1'b0;
    if4.in_valid = 1'b1; if4.in_data = build4(8'h11, 2); if4.sel = 2'd2;
    step();
    check("bp_first", 32'(if4.out_data), 32'h11);
    check("bp_first_rdy", 32'(if4.in_ready), 32'd1);
    if4.in_data = build4(8'h22, 3); if4.sel = 2'd3;
    step();
    check("bp_full_rdy", 32'(if4.in_ready), 32'd0);
    check("bp_full_data", 32'(if4.out_data), 32'h11);
    if4.in_data = build4(8'h33, 1); if4.sel = 2'd1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("bp_hold_valid", 32'(if4.out_valid), 32'd1);
      check("bp_hold_data", 32'(if4.out_data), 32'h11);
      check("bp_hold_rdy", 32'(if4.in_ready), 32'd0);
    end
    if4.out_ready = 1'b1;
    step();
    check("bp_rel_data2", 32'(if4.out_data), 32'h22);
    check("bp_rel_rdy", 32'(if4.in_ready), 32'd1);
    step();
    check("bp_rel_data3", 32'(if4.out_data), 32'h33);
    if4.in_valid = 1'b0;
    step();
    check("bp_rel_empty", 32'(if4.out_valid), 32'd0);

    // Flush while full with a word on offer
    if4.out_ready = 1'b0;
    if4.in_valid = 1'b1; if4.in_data = build4(8'h44, 0); if4.sel = 2'd0;
    step();
    if4.in_data = build4(8'h55, 1); if4.sel = 2'd1;
    step();
    check("fl_full_rdy", 32'(if4.in_ready), 32'd0);
    if4.in_data = build4(8'h66, 2); if4.sel = 2'd2; if4.flush = 1'b1;
    step();
    check("fl_out_valid", 32'(if4.out_valid), 32'd0);
    check("fl_in_ready", 32'(if4.in_ready), 32'd1);
    check("fl_out_data_kept", 32'(if4.out_data), 32'h44);
    if4.flush = 1'b0; if4.in_valid = 1'b0; if4.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("fl_nothing_later", 32'(if4.out_valid), 32'd0);
    end

    // Random valid/ready against a reference queue
    stall = 1'b0; hold_in = 1'b0; held = '0;
    for (int c = 0; c < 10000; c++) begin
      if (!hold_in) begin
        if4.in_valid = ($urandom_range(0, 3) != 0);
        if4.in_data  = $urandom;
        if4.sel      = 2'($urandom_range(0, 3));
      end
      if4.out_ready = ($urandom_range(0, 2) != 0);
      if (stall) begin
        check("rnd_hold_valid", 32'(if4.out_valid), 32'd1);
        check("rnd_hold_data", 32'(if4.out_data), 32'(held));
      end
      if (if4.out_valid && if4.out_ready) begin
        if (q.size() == 0) begin
          check("rnd_out_when_empty", 32'(q.size()), 32'd1);
        end else begin
          exp_w = q.pop_front();
          check("rnd_stream", 32'(if4.out_data), 32'(exp_w));
        end
      end
      if (if4.in_valid && if4.in_ready) begin
        q.push_back(pick4(if4.in_data, if4.sel));
      end
      stall   = if4.out_valid && !if4.out_ready;
      held    = if4.out_data;
      hold_in = if4.in_valid && !if4.in_ready;
      step();
    end
    if4.in_valid = 1'b0; if4.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (if4.out_valid) begin
        if (q.size() == 0) begin
          check("drain_out_when_empty", 32'(q.size()), 32'd1);
        end else begin
          exp_w = q.pop_front();
          check("drain_stream", 32'(if4.out_data), 32'(exp_w));
        end
      end
      step();
    end
    check("drain_queue_empty", 32'(q.size()), 32'd0);
    check("drain_out_valid", 32'(if4.out_valid), 32'd0);

    // Out-of-range select on a 3-input stage
    if3.in_data = {5'h07, 5'h15, 5'h0A};
    if3.in_valid = 1'b1; if3.sel = 2'd3;
    step();
    check("oob_valid", 32'(if3.out_valid), 32'd1);
    check("oob_data_zero", 32'(if3.out_data), 32'd0);
    check("oob_sel_err", 32'(if3.sel_err), EXP_ERR);
    if3.sel = 2'd2;
    step();
    check("inr_data", 32'(if3.out_data), 32'h07);
    check("inr_sel_err", 32'(if3.sel_err), EXP_ERR);
    if3.in_valid = 1'b0; if3.flush = 1'b1;
    step();
    if3.flush = 1'b0;
    check("flush_sel_err", 32'(if3.sel_err), EXP_ERR);
    check("flush_out_valid", 32'(if3.out_valid), 32'd0);
    step();
    check("flush_sel_err2", 32'(if3.sel_err), EXP_ERR);
    check("pow2_sel_err", 32'(if2.sel_err), 32'd0);
    rst = 1'b1;
    step();
    check("rst_clears_sel_err", 32'(if3.sel_err), 32'd0);
    check("rst_clears_data", 32'(if3.out_data), 32'd0);
    rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_n_pipe.md
Name: mux_n_pipe

Overview:
- Parametrised N:1 selector with one registered pipeline stage and valid/ready flow control on both sides.
- Generalised successor of the 5-bit 2:1 select used on the register-destination path. Sits between decode and the register-file write-address/data staging in the datapath.
- Contains a 2-entry skid buffer, so `in_ready` is registered and the stage sustains one transfer per cycle under backpressure.

Parameters:
- WIDTH, 5, data width of each input channel and of the output.
- NUM_IN, 2, number of input channels (2..16).
- SEL_W, 1, select width. Must satisfy 2**SEL_W >= NUM_IN.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  NUM_IN*WIDTH  flattened channels; channel k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SEL_W  channel index, sampled together with `in_data` on accept.
- in_valid  input  1  upstream has a transfer.
- in_ready  output  1  stage can accept.
- out_data  output  WIDTH  selected, registered data.
- out_valid  output  1  `out_data` is valid.
- out_ready  input  1  downstream accepts.
- flush  input  1  discard all held transfers.
- sel_err  output  1  sticky out-of-range select flag (see Optional Feature).

Behaviour:
- Clocking and reset:
  - Single clock domain. All state updates on the rising edge of `clk`.
  - `rst` is synchronous and active-high.
- Reset values (while `rst` is sampled high):
  - `out_valid`=0, `out_data`=0, skid_valid=0, `sel_err`=0.
  - `in_ready`=0 during reset; `in_ready`=1 from the first cycle after `rst` deasserts.
- Handshake:
  - Accept = `in_valid` & `in_ready`.
  - Output transfer = `out_valid` & `out_ready`.
  - Upstream holds `in_data`/`sel` stable while `in_valid`=1 and `in_ready`=0.
- Selection:
  - Selected word = channel `sel` of `in_data`, registered on accept.
  - Latency: data accepted at edge N appears on `out_data` with `out_valid`=1 after edge N (one cycle).
- Storage: main register (drives `out_*`) plus one skid register.
  - EMPTY (`out_valid`=0): accept loads main.
  - ONE (`out_valid`=1, skid empty):
    - Accept with output transfer: main <= new word.
    - Accept without output transfer: skid <= new word → FULL.
    - Output transfer only → EMPTY.
  - FULL (both valid): `in_ready`=0.
    - Output transfer: main <= skid, skid empties → ONE.
    - No new accept in FULL.
- `in_ready` = ~skid_valid, registered; no combinational path from `out_ready`.
- `out_data` is stable while `out_valid`=1 and `out_ready`=0.
- Flush:
  - Clears main valid and skid valid at the edge; any accept that cycle is dropped.
  - `out_valid`=0 next cycle; `out_data` keeps its last value.
- Priority: `rst` > `flush` > normal operation.
- Reset mid-transfer: all held words are lost; no partial output.
- Out-of-range select (`sel` >= NUM_IN): selected word = 0. The transfer still completes normally.

Optional Feature:
- Macro: MUX_N_PIPE_SEL_CHECK_EN.
- Defined:
  - An accept with `sel` >= NUM_IN sets `sel_err`=1 from the next cycle.
  - `sel_err` stays set until `rst`; `flush` does not clear it.
  - With NUM_IN a power of two the check is constant-false.
- Not defined: `sel_err` tied to 0 and no check logic is built. Data behaviour (zero word) is identical either way.

Test Plan:
- WIDTH=5, NUM_IN=2. Hold `rst`=1 for 2 cycles with `in_valid`=1 → `out_valid`=0, `out_data`=0, `in_ready`=0 during reset; `in_ready`=1 on the first cycle after release.
- `in_data`={5'h1A,5'h05}, `sel`=1, `out_ready`=1 → `out_data`=5'h1A, `out_valid`=1 one cycle after accept. Repeat with `sel`=0 → 5'h05. Streaming every cycle gives one output per cycle, in order.
- Backpressure, NUM_IN=4, WIDTH=8:
  - Set `out_ready`=0 and offer words 0x11, 0x22, 0x33.
  - Expect 0x11 held on output, 0x22 in skid, `in_ready`=0 while 0x33 waits.
  - Release `out_ready` → outputs 0x11, 0x22, 0x33 in order, nothing lost or duplicated.
- Flush with the buffer FULL and `in_valid`=1 on the same cycle → `out_valid`=0 next cycle, `in_ready`=1, and the offered word is not delivered later.
- NUM_IN=3, SEL_W=2, `sel`=3:
  - `out_data`=0 in all builds.
  - With MUX_N_PIPE_SEL_CHECK_EN: `sel_err`=1 and stays 1 through a `flush`, clearing only on `rst`.
  - Without the macro: `sel_err`=0.
- Random `in_valid`/`out_ready` for 10k cycles against a reference queue model → output order and values match; `out_data` never changes while `out_valid`=1 and `out_ready`=0.
